imem_arb: RTL and testbench

IMEM_ARB -- requirements
Module: imem_arb

---
 rtl/imem_arb.sv | 157 +++++++++++++++
 tb/tb_imem_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arb.sv
// Two-requester arbiter in front of a single-port instruction memory with one-cycle read latency.
// Fixed priority (m0 wins) by default; define IMEM_ARB_RR_EN for round-robin arbitration.
module imem_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rerr,
  input  logic          m0_rready,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rerr,
  input  logic          m1_rready,
  output logic          imem_re,
  output logic [AW-1:0] imem_a,
  input  logic [DW-1:0] imem_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          err_q, err_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          hold_err_q, hold_err_d;

  logic          owner_rready;
  logic          can_grant;
  logic          prefer_m1;
  logic          gnt0, gnt1, gnt_any;
  logic [AW-1:0] gnt_addr;
  logic          gnt_err;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_err;

`ifdef IMEM_ARB_RR_EN
  // Last granted port; reset value 1 so m0 wins the first tie.
  logic last_q, last_d;

  always_comb begin
    prefer_m1 = (last_q == 1'b0);
    last_d    = gnt_any ? gnt1 : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    prefer_m1 = 1'b0;
  end
`endif

  // Arbitration, memory request and response steering.
  always_comb begin
    owner_rready = owner_q ? m1_rready : m0_rready;
    can_grant    = (state_q == IDLE) || ((state_q == RESP) && owner_rready);

    gnt0    = rst_n && can_grant && m0_req && !(m1_req && prefer_m1);
    gnt1    = rst_n && can_grant && m1_req && !gnt0;
    gnt_any = gnt0 || gnt1;

    gnt_addr = gnt1 ? m1_addr : m0_addr;
    gnt_err  = (gnt_addr[1:0] != 2'b00);

    imem_re = gnt_any && !gnt_err;
    imem_a  = gnt_any ? gnt_addr : '0;

    resp_valid = (state_q == RESP) || (state_q == HOLD);
    resp_data  = '0;
    resp_err   = 1'b0;
    if (state_q == RESP) begin
      resp_data = err_q ? '0 : imem_rd;
      resp_err  = err_q;
    end else if (state_q == HOLD) begin
      resp_data = hold_data_q;
      resp_err  = hold_err_q;
    end

    m0_gnt    = gnt0;
    m1_gnt    = gnt1;
    m0_rvalid = resp_valid && !owner_q;
    m1_rvalid = resp_valid && owner_q;
    m0_rdata  = m0_rvalid ? resp_data : '0;
    m1_rdata  = m1_rvalid ? resp_data : '0;
    m0_rerr   = m0_rvalid && resp_err;
    m1_rerr   = m1_rvalid && resp_err;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    err_d       = err_q;
    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;

    case (state_q)
      IDLE: begin
        if (gnt_any) state_d = RESP;
      end
      RESP: begin
        if (owner_rready) begin
          state_d = gnt_any ? RESP : IDLE;
        end else begin
          // Memory data is only valid this cycle; park it until the owner is ready.
          state_d     = HOLD;
          hold_data_d = resp_data;
          hold_err_d  = resp_err;
        end
      end
      HOLD: begin
        if (owner_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (gnt_any) begin
      owner_d = gnt1;
      err_d   = gnt_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      err_q       <= 1'b0;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      hold_data_q <= hold_data_d;
      hold_err_q  <= hold_err_d;
    end
  end

endmodule

// File: tb/tb_imem_arb.sv
// Bench for imem_arb: transaction-level model checked every cycle plus directed literal checks.
// Build with +define+IMEM_ARB_RR_EN to check the round-robin variant.
module tb_imem_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m1_req, m0_rready, m1_rready;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          imem_re;
  logic [AW-1:0] imem_a;
  logic [DW-1:0] imem_rd;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  imem_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_rerr(m0_rerr), .m0_rready(m0_rready),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_rerr(m1_rerr), .m1_rready(m1_rready),
    .imem_re(imem_re), .imem_a(imem_a), .imem_rd(imem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: valid data one cycle after a read, junk otherwise.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    imem_rd <= imem_re ? mem_f(imem_a) : (32'hDEAD_0000 | cyc[15:0]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: at most one outstanding response. fresh=1 means it is being
  // delivered for the first time (grants may chain); fresh=0 means it is parked.
  logic          pv, po, pe, pf;
  logic [DW-1:0] pd;
  logic          last_gnt;

  always @(negedge clk) begin
    logic can, w0, w1, ordy, tie_m1;
    logic [AW-1:0] ga;
    if (!rst_n) begin
      chk("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
      chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      chk("rst_rerr", {m0_rerr, m1_rerr}, 2'b00);
      chk("rst_re", imem_re, 1'b0);
      chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
      pv = 1'b0; pf = 1'b0; po = 1'b0; pe = 1'b0; pd = '0;
      last_gnt = 1'b1;
    end else begin
      ordy = po ? m1_rready : m0_rready;
      can  = !pv || (pf && ordy);
`ifdef IMEM_ARB_RR_EN
      tie_m1 = (last_gnt == 1'b0);
`else
      tie_m1 = 1'b0;
`endif
      w0 = 1'b0; w1 = 1'b0;
      if (can) begin
        if (m0_req && m1_req) begin
          w1 = tie_m1; w0 = !tie_m1;
        end else begin
          w0 = m0_req; w1 = m1_req;
        end
      end
      ga = w1 ? m1_addr : m0_addr;
      chk("m_gnt", {m0_gnt, m1_gnt}, {w0, w1});
      chk("m_re", imem_re, (w0 || w1) && (ga[1:0] == 2'b00));
      if (w0 || w1) chk("m_addr", imem_a, ga);
      chk("m_rvalid", {m0_rvalid, m1_rvalid}, {pv && !po, pv && po});
      if (pv && !po) chk("m_rdata0", {m0_rerr, m0_rdata}, {pe, pd});
      if (pv && po)  chk("m_rdata1", {m1_rerr, m1_rdata}, {pe, pd});
      if (pv && ordy) pv = 1'b0;
      else if (pv) pf = 1'b0;
      if (w0 || w1) begin
        pv = 1'b1; pf = 1'b1; po = w1;
        pe = (ga[1:0] != 2'b00);
        pd = pe ? '0 : mem_f(ga);
        last_gnt = w1;
      end
    end
  end

  typedef struct {
    logic r0, r1, y0, y1;
    logic [AW-1:0] a0, a1;
  } vec_t;

  initial begin
    logic [5:0] g1hist;
    int g0cnt;
    vec_t vt[10];
    rst_n = 1'b0;
    m0_req = 0; m1_req = 0; m0_addr = '0; m1_addr = '0;
    m0_rready = 1; m1_rready = 1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Aligned fetch, one-cycle latency.
    m0_req = 1; m0_addr = 32'h10;
    #1;
    chk("fetch_gnt", {m0_gnt, imem_re}, 2'b11);
    chk("fetch_a", imem_a, 32'h10);
    tick();
    m0_req = 0;
    chk("fetch_rvalid", m0_rvalid, 1'b1);
    chk("fetch_rdata", m0_rdata, 32'hA5A5_0010);
    chk("fetch_rerr", m0_rerr, 1'b0);
    tick();

    // Misaligned address.
    m0_req = 1; m0_addr = 32'h6;
    #1;
    chk("mis_gnt_re", {m0_gnt, imem_re}, 2'b10);
    chk("mis_a", imem_a, 32'h6);
    tick();
    m0_req = 0;
    chk("mis_resp", {m0_rvalid, m0_rerr, m0_rdata}, {1'b1, 1'b1, 32'h0});
    tick();

    // Both request continuously.
    m0_req = 1; m0_addr = 32'h40; m1_req = 1; m1_addr = 32'h80;
    g1hist = '0; g0cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      g1hist[i] = m1_gnt;
      g0cnt += m0_gnt;
      tick();
    end
    m0_req = 0; m1_req = 0;
`ifdef IMEM_ARB_RR_EN
    // m0 was granted last, so m1 wins the first tie.
    chk("rr_pattern", g1hist, 6'b010101);
    chk("rr_m0_cnt", g0cnt, 3);
`else
    chk("fp_pattern", g1hist, 6'b000000);
    chk("fp_m0_cnt", g0cnt, 6);
`endif
    tick();

    // m1 read stalled by rready=0.
    m1_req = 1; m1_addr = 32'h20; m1_rready = 0;
    #1;
    chk("hold_gnt", m1_gnt, 1'b1);
    tick();
    m1_req = 0; m0_req = 1; m0_addr = 32'h30;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_rvalid", m1_rvalid, 1'b1);
      chk("hold_rdata", m1_rdata, 32'hA5A5_0020);
      chk("hold_nognt", {m0_gnt, m1_gnt}, 2'b00);
      tick();
    end
    m1_rready = 1;
    #1;
    chk("hold_rel_nognt", {m1_rvalid, m0_gnt}, 2'b10);
    tick();
    chk("hold_idle", {m1_rvalid, m0_gnt}, 2'b01);
    m0_req = 0;
    tick();
    tick();

    // Reset while a response is parked.
    m1_req = 1; m1_addr = 32'h24; m1_rready = 0;
    tick();
    m1_req = 0;
    tick();
    m0_req = 1; m0_addr = 32'h50;
    #1;
    chk("pre_rst_rvalid", m1_rvalid, 1'b1);
    rst_n = 0;
    #1;
    chk("rst_async_out", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, imem_re, m1_rerr}, 6'b0);
    chk("rst_async_data", m1_rdata, 32'h0);
    m0_req = 0;
    tick();
    tick();
    rst_n = 1; m1_rready = 1;
    #1;
    chk("post_rst_nostale", {m1_rvalid, m0_gnt, m1_gnt}, 3'b000);
    tick();
    chk("post_rst_nostale2", m1_rvalid, 1'b0);

    // Mixed traffic, checked by the model.
    vt[0] = '{1, 0, 1, 1, 32'h100, 32'h0};
    vt[1] = '{1, 1, 1, 1, 32'h104, 32'h200};
    vt[2] = '{0, 1, 1, 0, 32'h0,   32'h201};
    vt[3] = '{0, 1, 1, 0, 32'h0,   32'h204};
    vt[4] = '{1, 0, 1, 1, 32'h108, 32'h0};
    vt[5] = '{1, 1, 0, 1, 32'h10C, 32'h208};
    vt[6] = '{1, 1, 0, 1, 32'h10C, 32'h208};
    vt[7] = '{1, 1, 1, 1, 32'h10E, 32'h20C};
    vt[8] = '{0, 1, 1, 1, 32'h0,   32'h210};
    vt[9] = '{0, 0, 1, 1, 32'h0,   32'h0};
    for (int i = 0; i < 10; i++) begin
      m0_req = vt[i].r0; m1_req = vt[i].r1;
      m0_rready = vt[i].y0; m1_rready = vt[i].y1;
      m0_addr = vt[i].a0; m1_addr = vt[i].a1;
      tick();
    end
    m0_req = 0; m1_req = 0; m0_rready = 1; m1_rready = 1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
